branch_update_scheduler: RTL
============================

BRANCH_UPDATE_SCHEDULER -- requirements
Module: branch_update_scheduler

Interface
REQ-001 SHALL have parameter BW_ADDRESS, default 32, PC width.
REQ-002 SHALL have parameter NUM_GLOBAL_HISTORY, default 4, history width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of 2, >=2.
REQ-004 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports i_rq0_valid / i_rq1_valid  input  1 each  requester k presents a resolved branch.
REQ-007 SHALL have ports o_rq0_ready / o_rq1_ready  output  1 each  requester k accepted this cycle when valid&ready.
REQ-008 SHALL have ports i_rqK_pc, i_rqK_correct_pc_next  input  BW_ADDRESS each (K=0,1)  branch PC, resolved next PC.
REQ-009 SHALL have ports i_rqK_global_history  input  NUM_GLOBAL_HISTORY, and i_rqK_correct_prediction  input  1 (K=0,1).
REQ-010 SHALL have port i_flush  input  1  discard all queued updates.
REQ-011 SHALL have ports o_upd_valid  output  1, i_upd_ready  input  1  update handshake toward predictor.
REQ-012 SHALL have ports o_upd_pc, o_upd_correct_pc_next  output  BW_ADDRESS; o_upd_global_history  output  NUM_GLOBAL_HISTORY; o_upd_correct_prediction  output  1.
REQ-013 SHALL have port o_count  output  $clog2(DEPTH)+1  entries held.

Function
REQ-014 SHALL store entries {pc, correct_pc_next, global_history, correct_prediction} in a circular FIFO with head/tail pointers and count.
REQ-015 SHALL drive o_upd_valid = (count != 0); o_upd_* = head entry, combinational from registers, stable while valid & !ready.
REQ-016 SHALL dequeue one entry per cycle when o_upd_valid & i_upd_ready; head advances mod DEPTH.
REQ-017 SHALL compute free = DEPTH - count from registered count only; same-cycle dequeue SHALL NOT create space for enqueue.
REQ-018 SHALL hold 1-bit priority pointer prio (0 = requester 0 first).
REQ-019 free>=2: both ready high; both valid -> both enqueued, prio requester at tail, other at tail+1; prio flips.
REQ-020 free==1: only one ready high -- prio requester if its valid is high, else the other; if both valid, prio requester enqueued, prio flips.
REQ-021 free==0: both ready low; no enqueue.
REQ-022 Single requester valid with free>=1: enqueued, prio unchanged.
REQ-023 Ready SHALL depend only on registered state and the two valid inputs (no dependence on i_upd_ready).
REQ-024 count_next = count + enqueued - dequeued; simultaneous enqueue and dequeue at count==DEPTH SHALL NOT occur (ready low), at count 0 dequeue SHALL NOT occur.
REQ-025 i_flush high: next cycle count=0, head=tail=0; both ready forced low that cycle; dequeue handshake ignored; prio unchanged.
REQ-026 Entries SHALL be delivered in enqueue order; no reordering, no drop except flush.

Reset
REQ-027 rst_n low SHALL immediately clear count, head, tail, prio to 0; o_upd_valid=0, o_count=0, both ready low while rst_n low.
REQ-028 Entry storage need not be reset; o_upd_* data are don't-care while o_upd_valid=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries; first accepted request after release appears at head.

Verification
REQ-030 Empty, rq0 valid pc=0x100, upd_ready=1 -> next cycle o_upd_valid=1, o_upd_pc=0x100, count=1; following cycle count=0.
REQ-031 Empty, both valid (pc0=0x10, pc1=0x20), prio=0 -> both ready; outputs in order 0x10 then 0x20; prio=1 after.
REQ-032 count=3 (DEPTH=4), both valid, prio=1 -> only o_rq1_ready=1; count=4; prio=0; next cycle both ready low even with upd_ready=1.
REQ-033 upd_ready=0 for 5 cycles with count=2 -> o_upd_* held constant, count=2.
REQ-034 count=3, i_flush=1 with both valid and upd_ready=1 -> readies low, next cycle count=0, o_upd_valid=0.
REQ-035 Fill/drain 3xDEPTH entries alternating requesters -> pointer wrap, order preserved, count never exceeds DEPTH.

Source files
------------

// File: rtl/branch_update_scheduler.sv
// Two-requester branch-update queue feeding the predictor.
// Fair ordering of simultaneous updates via a rotating priority bit.
module branch_update_scheduler #(
  parameter int BW_ADDRESS         = 32,
  parameter int NUM_GLOBAL_HISTORY = 4,
  parameter int DEPTH              = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,

  input  logic                          i_rq0_valid,
  output logic                          o_rq0_ready,
  input  logic [BW_ADDRESS-1:0]         i_rq0_pc,
  input  logic [BW_ADDRESS-1:0]         i_rq0_correct_pc_next,
  input  logic [NUM_GLOBAL_HISTORY-1:0] i_rq0_global_history,
  input  logic                          i_rq0_correct_prediction,

  input  logic                          i_rq1_valid,
  output logic                          o_rq1_ready,
  input  logic [BW_ADDRESS-1:0]         i_rq1_pc,
  input  logic [BW_ADDRESS-1:0]         i_rq1_correct_pc_next,
  input  logic [NUM_GLOBAL_HISTORY-1:0] i_rq1_global_history,
  input  logic                          i_rq1_correct_prediction,

  input  logic                          i_flush,

  output logic                          o_upd_valid,
  input  logic                          i_upd_ready,
  output logic [BW_ADDRESS-1:0]         o_upd_pc,
  output logic [BW_ADDRESS-1:0]         o_upd_correct_pc_next,
  output logic [NUM_GLOBAL_HISTORY-1:0] o_upd_global_history,
  output logic                          o_upd_correct_prediction,

  output logic [$clog2(DEPTH):0]        o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * BW_ADDRESS + NUM_GLOBAL_HISTORY + 1;

  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          prio_q, prio_d;

  logic [CW-1:0] free;
  logic          rdy0, rdy1;
  logic          acc0, acc1;
  logic          deq;
  logic [1:0]    n_enq;

  logic          wa_en, wb_en;
  logic [AW-1:0] wa_idx, wb_idx;
  logic [EW-1:0] wa_data, wb_data;
  logic [EW-1:0] ent0, ent1;

  assign ent0 = {i_rq0_pc, i_rq0_correct_pc_next,
                 i_rq0_global_history,
                 i_rq0_correct_prediction};
  assign ent1 = {i_rq1_pc, i_rq1_correct_pc_next,
                 i_rq1_global_history,
                 i_rq1_correct_prediction};

  // Space is judged on the registered count only.
  assign free = CW'(DEPTH) - count_q;

  always_comb begin
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    if (rst_n && !i_flush) begin
      unique case (1'b1)
        (free >= CW'(2)): begin
          rdy0 = 1'b1;
          rdy1 = 1'b1;
        end
        (free == CW'(1)): begin
          if (!prio_q) begin
            rdy0 = i_rq0_valid;
            rdy1 = !i_rq0_valid;
          end else begin
            rdy1 = i_rq1_valid;
            rdy0 = !i_rq1_valid;
          end
        end
        default: begin
          rdy0 = 1'b0;
          rdy1 = 1'b0;
        end
      endcase
    end
  end

  assign acc0  = i_rq0_valid & rdy0;
  assign acc1  = i_rq1_valid & rdy1;
  assign n_enq = {1'b0, acc0} + {1'b0, acc1};
  assign deq   = (count_q != '0) & i_upd_ready & !i_flush;

  always_comb begin
    wa_en   = 1'b0;
    wb_en   = 1'b0;
    wa_idx  = tail_q;
    wb_idx  = tail_q + AW'(1);
    wa_data = ent0;
    wb_data = ent1;
    if (acc0 && acc1) begin
      wa_en   = 1'b1;
      wb_en   = 1'b1;
      wa_data = prio_q ? ent1 : ent0;
      wb_data = prio_q ? ent0 : ent1;
    end else if (acc0) begin
      wa_en   = 1'b1;
      wa_data = ent0;
    end else if (acc1) begin
      wa_en   = 1'b1;
      wa_data = ent1;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    prio_d  = prio_q;
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(deq);
      tail_d  = tail_q + AW'(n_enq);
      count_d = count_q + CW'(n_enq) - CW'(deq);
      // Rotate only when both competed and one won.
      prio_d  = prio_q ^ (i_rq0_valid & i_rq1_valid
                          & (acc0 | acc1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      prio_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      prio_q  <= prio_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wa_en) mem_q[wa_idx] <= wa_data;
    if (wb_en) mem_q[wb_idx] <= wb_data;
  end

  assign o_rq0_ready = rdy0;
  assign o_rq1_ready = rdy1;
  assign o_upd_valid = (count_q != '0);
  assign o_count     = count_q;
  assign {o_upd_pc, o_upd_correct_pc_next,
          o_upd_global_history,
          o_upd_correct_prediction} = mem_q[head_q];

endmodule
